// File: rtl/wm_pkg.sv
// Shared phase codes and default thresholds/durations for the washing-machine controller and
// its phase monitor.
package wm_pkg;

  typedef enum logic [2:0] {
    PhIdle  = 3'd0,
    PhFill  = 3'd1,
    PhHeat  = 3'd2,
    PhWash  = 3'd3,
    PhRinse = 3'd4,
    PhSpin  = 3'd5,
    PhFault = 3'd6
  } phase_e;

  localparam int unsigned DefSensW       = 8;
  localparam int unsigned DefCntW        = 16;
  localparam int unsigned DefFullLevel   = 200;
  localparam int unsigned DefTargetTemp  = 60;
  localparam int unsigned DefDebounce    = 4;
  localparam int unsigned DefFillTimeout = 1000;
  localparam int unsigned DefHeatTimeout = 2000;
  localparam int unsigned DefWashCycles  = 500;
  localparam int unsigned DefRinseCycles = 300;
  localparam int unsigned DefSpinCycles  = 200;

endpackage

// File: rtl/wm_threshold_debounce.sv
// Sticky threshold detector: sets after Debounce consecutive enabled samples at or above the
// threshold, holds until cleared.
module wm_threshold_debounce #(
  parameter int unsigned SensW    = 8,
  parameter int unsigned Debounce = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SensW-1:0] sample_i,
  input  logic [SensW-1:0] threshold_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             hit_o,
  output logic             hit_next_o
);

  localparam int unsigned RunW = $clog2(Debounce + 1);

  logic [RunW-1:0] run_q, run_d;
  logic            hit_q, hit_d;

  always_comb begin
    run_d = run_q;
    hit_d = hit_q;
    if (clear_i) begin
      run_d = '0;
      hit_d = 1'b0;
    end else if (enable_i && !hit_q) begin
      if (sample_i >= threshold_i) begin
        run_d = run_q + 1'b1;
        hit_d = (run_q == RunW'(Debounce - 1));
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_q <= '0;
      hit_q <= 1'b0;
    end else begin
      run_q <= run_d;
      hit_q <= hit_d;
    end
  end

  assign hit_o      = hit_q;
  // Lets the watchdog see a hit landing on the same edge as its deadline.
  assign hit_next_o = hit_d;

endmodule

// File: rtl/wm_phase_monitor.sv
// Decodes the controller's operation outputs into a phase, times it, and produces the debounced
// threshold, phase-completion and fill/heat watchdog levels the controller waits on.
module wm_phase_monitor
  import wm_pkg::*;
#(
  parameter int unsigned     SensW       = DefSensW,
  parameter int unsigned     CntW        = DefCntW,
  parameter logic [SensW-1:0] FullLevel  = SensW'(DefFullLevel),
  parameter logic [SensW-1:0] TargetTemp = SensW'(DefTargetTemp),
  parameter int unsigned     Debounce    = DefDebounce,
  parameter int unsigned     FillTimeout = DefFillTimeout,
  parameter int unsigned     HeatTimeout = DefHeatTimeout,
  parameter int unsigned     WashCycles  = DefWashCycles,
  parameter int unsigned     RinseCycles = DefRinseCycles,
  parameter int unsigned     SpinCycles  = DefSpinCycles
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fill_Water_Operation,
  input  logic             heat_Water_Operation,
  input  logic             wash_Operation,
  input  logic             rinse_Operation,
  input  logic             spin_Operation,
  input  logic             fault,
  input  logic [SensW-1:0] level_Sensor,
  input  logic [SensW-1:0] temp_Sensor,
  output logic             sig_Full,
  output logic             sig_Temperature,
  output logic             sig_Wash_Completed,
  output logic             sig_Rinse_Completed,
  output logic             sig_Spin_Completed,
  output logic             sig_Time_Out,
  output logic             op_Conflict,
  output logic [2:0]       phase,
  output logic [CntW-1:0]  phase_Count
);

  phase_e          phase_q, phase_d, dec_phase;
  logic [CntW-1:0] count_q, count_d;
  logic            conflict_q, conflict_d;
  logic            timeout_q, timeout_d;
  logic            wash_q, wash_d, rinse_q, rinse_d, spin_q, spin_d;
  logic            stay, fill_en, heat_en;
  logic            full_next, temp_next;
  logic [4:0]      ops;

  assign ops = {fill_Water_Operation, heat_Water_Operation, wash_Operation, rinse_Operation,
                spin_Operation};

  always_comb begin
    unique case (ops)
      5'b10000: dec_phase = PhFill;
      5'b01000: dec_phase = PhHeat;
      5'b00100: dec_phase = PhWash;
      5'b00010: dec_phase = PhRinse;
      5'b00001: dec_phase = PhSpin;
      default:  dec_phase = PhIdle;
    endcase
  end

  always_comb begin
    // Any fault or phase change restarts timer, debounce and every level output.
    stay       = !fault && (dec_phase == phase_q);
    phase_d    = fault ? PhIdle : dec_phase;
    count_d    = '0;
    if (stay) count_d = (count_q == '1) ? count_q : count_q + 1'b1;
    conflict_d = !fault && ((ops & (ops - 5'd1)) != 5'd0);
    fill_en    = stay && (phase_q == PhFill);
    heat_en    = stay && (phase_q == PhHeat);

    timeout_d = 1'b0;
    if (fill_en) begin
      timeout_d = timeout_q || ((count_q == CntW'(FillTimeout - 1)) && !full_next);
    end else if (heat_en) begin
      timeout_d = timeout_q || ((count_q == CntW'(HeatTimeout - 1)) && !temp_next);
    end

    wash_d  = stay && (phase_q == PhWash)
              && (wash_q || (count_q == CntW'(WashCycles - 1)));
    rinse_d = stay && (phase_q == PhRinse)
              && (rinse_q || (count_q == CntW'(RinseCycles - 1)));
    spin_d  = stay && (phase_q == PhSpin)
              && (spin_q || (count_q == CntW'(SpinCycles - 1)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q    <= PhIdle;
      count_q    <= '0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
      wash_q     <= 1'b0;
      rinse_q    <= 1'b0;
      spin_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      count_q    <= count_d;
      conflict_q <= conflict_d;
      timeout_q  <= timeout_d;
      wash_q     <= wash_d;
      rinse_q    <= rinse_d;
      spin_q     <= spin_d;
    end
  end

  wm_threshold_debounce #(
    .SensW    (SensW),
    .Debounce (Debounce)
  ) u_level_debounce (
    .clock       (clock),
    .reset       (reset),
    .sample_i    (level_Sensor),
    .threshold_i (FullLevel),
    .enable_i    (fill_en),
    .clear_i     (!fill_en),
    .hit_o       (sig_Full),
    .hit_next_o  (full_next)
  );

  wm_threshold_debounce #(
    .SensW    (SensW),
    .Debounce (Debounce)
  ) u_temp_debounce (
    .clock       (clock),
    .reset       (reset),
    .sample_i    (temp_Sensor),
    .threshold_i (TargetTemp),
    .enable_i    (heat_en),
    .clear_i     (!heat_en),
    .hit_o       (sig_Temperature),
    .hit_next_o  (temp_next)
  );

  assign sig_Wash_Completed  = wash_q;
  assign sig_Rinse_Completed = rinse_q;
  assign sig_Spin_Completed  = spin_q;
  assign sig_Time_Out        = timeout_q;
  assign op_Conflict         = conflict_q;
  assign phase               = phase_q;
  assign phase_Count         = count_q;

endmodule

// File: tb/tb_wm_phase_monitor.sv
// Self-checking bench for wm_phase_monitor: directed phase scenarios plus randomized operation
// and sensor traffic, all compared cycle by cycle against a behavioural model.
module tb_wm_phase_monitor;
  import wm_pkg::*;

  localparam int FULL = 200, TEMP = 60, DEB = 4;
  localparam int FTO = 1000, HTO = 2000, WC = 500, RC = 300, SC = 200, CMAX = 65535;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fill_op = 1'b0, heat_op = 1'b0, wash_op = 1'b0, rinse_op = 1'b0, spin_op = 1'b0;
  logic        fault = 1'b0;
  logic [7:0]  level = 8'd0, temp = 8'd0;
  logic        sig_full, sig_temp, sig_wash, sig_rinse, sig_spin, sig_to, op_conflict;
  logic [2:0]  phase;
  logic [15:0] phase_count;

  int checks = 0, failures = 0;

  // Behavioural model state
  int m_phase, m_cnt, m_run_l, m_run_t;
  bit m_full, m_temp, m_to, m_wash, m_rinse, m_spin, m_conf;

  always #5 clock = ~clock;

  wm_phase_monitor #(
    .SensW(8), .CntW(16), .FullLevel(8'd200), .TargetTemp(8'd60), .Debounce(4),
    .FillTimeout(1000), .HeatTimeout(2000), .WashCycles(500), .RinseCycles(300),
    .SpinCycles(200)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .fill_Water_Operation (fill_op),
    .heat_Water_Operation (heat_op),
    .wash_Operation       (wash_op),
    .rinse_Operation      (rinse_op),
    .spin_Operation       (spin_op),
    .fault                (fault),
    .level_Sensor         (level),
    .temp_Sensor          (temp),
    .sig_Full             (sig_full),
    .sig_Temperature      (sig_temp),
    .sig_Wash_Completed   (sig_wash),
    .sig_Rinse_Completed  (sig_rinse),
    .sig_Spin_Completed   (sig_spin),
    .sig_Time_Out         (sig_to),
    .op_Conflict          (op_conflict),
    .phase                (phase),
    .phase_Count          (phase_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_phase = int'(PhIdle);
    m_cnt = 0; m_run_l = 0; m_run_t = 0;
    m_full = 0; m_temp = 0; m_to = 0; m_wash = 0; m_rinse = 0; m_spin = 0; m_conf = 0;
  endtask

  task automatic model_step();
    int n_ops, dec;
    n_ops = int'(fill_op) + int'(heat_op) + int'(wash_op) + int'(rinse_op) + int'(spin_op);
    if (reset || fault) begin
      model_clear();
      return;
    end
    dec = int'(PhIdle);
    if (n_ops == 1) begin
      if (fill_op)       dec = int'(PhFill);
      else if (heat_op)  dec = int'(PhHeat);
      else if (wash_op)  dec = int'(PhWash);
      else if (rinse_op) dec = int'(PhRinse);
      else               dec = int'(PhSpin);
    end
    if (dec != m_phase) begin
      model_clear();
      m_phase = dec;
      m_conf  = (n_ops > 1);
      return;
    end
    m_conf = (n_ops > 1);
    if (m_phase == int'(PhFill)) begin
      if (!m_full) begin
        m_run_l = (int'(level) >= FULL) ? m_run_l + 1 : 0;
        if (m_run_l >= DEB) m_full = 1;
      end
      if (m_cnt == FTO - 1 && !m_full) m_to = 1;
    end else if (m_phase == int'(PhHeat)) begin
      if (!m_temp) begin
        m_run_t = (int'(temp) >= TEMP) ? m_run_t + 1 : 0;
        if (m_run_t >= DEB) m_temp = 1;
      end
      if (m_cnt == HTO - 1 && !m_temp) m_to = 1;
    end else if (m_phase == int'(PhWash)) begin
      if (m_cnt == WC - 1) m_wash = 1;
    end else if (m_phase == int'(PhRinse)) begin
      if (m_cnt == RC - 1) m_rinse = 1;
    end else if (m_phase == int'(PhSpin)) begin
      if (m_cnt == SC - 1) m_spin = 1;
    end
    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
  endtask

  task automatic compare_all();
    check("phase", phase, m_phase);
    check("phase_count", phase_count, m_cnt);
    check("op_conflict", op_conflict, m_conf);
    check("sig_full", sig_full, m_full);
    check("sig_temp", sig_temp, m_temp);
    check("sig_time_out", sig_to, m_to);
    check("sig_wash", sig_wash, m_wash);
    check("sig_rinse", sig_rinse, m_rinse);
    check("sig_spin", sig_spin, m_spin);
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_ops(input bit f, input bit h, input bit w, input bit r, input bit s);
    fill_op = f; heat_op = h; wash_op = w; rinse_op = r; spin_op = s;
  endtask

  initial begin
    model_clear();
    reset = 1'b1;
    repeat (3) step();
    check("reset_count", phase_count, 0);
    check("reset_phase", phase, int'(PhIdle));
    reset = 1'b0;

    // Steady full level: sig_Full after 4 qualifying samples following entry, then sticky.
    set_ops(1, 0, 0, 0, 0);
    level = 8'd210;
    step();
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) check("full_early", sig_full, 0);
      else begin
        check("full_on_4th", sig_full, 1);
        check("full_count", phase_count, 4);
      end
    end
    level = 8'd0;
    repeat (5) step();
    check("full_sticky", sig_full, 1);
    set_ops(0, 0, 0, 0, 0);
    step();
    check("full_exit", sig_full, 0);

    // Level toggling every 3 cycles never debounces; watchdog fires at count FTO.
    set_ops(1, 0, 0, 0, 0);
    for (int k = 0; k <= FTO; k++) begin
      level = (((k / 3) % 2) == 0) ? 8'd210 : 8'd0;
      step();
      if (phase_count == 16'(FTO - 1)) check("to_before", sig_to, 0);
      if (phase_count == 16'(FTO)) begin
        check("to_at_limit", sig_to, 1);
        check("to_full_low", sig_full, 0);
      end
    end

    // Wash then rinse completion timing.
    set_ops(0, 0, 1, 0, 0);
    for (int k = 0; k <= WC; k++) begin
      step();
      if (phase_count == 16'(WC - 1)) check("wash_before", sig_wash, 0);
      if (phase_count == 16'(WC)) check("wash_done", sig_wash, 1);
    end
    set_ops(0, 0, 0, 1, 0);
    step();
    check("rinse_entry_count", phase_count, 0);
    check("rinse_entry_wash", sig_wash, 0);
    for (int k = 1; k <= RC; k++) begin
      step();
      if (phase_count == 16'(RC - 1)) check("rinse_before", sig_rinse, 0);
      if (phase_count == 16'(RC)) check("rinse_done", sig_rinse, 1);
    end

    // Heat: 4th hit lands exactly on the watchdog deadline; completion wins.
    set_ops(0, 1, 0, 0, 0);
    temp = 8'd30;
    for (int k = 0; k <= HTO; k++) begin
      step();
      if (phase_count == 16'(HTO - 4)) temp = 8'd60;
      if (phase_count == 16'(HTO)) begin
        check("heat_temp_set", sig_temp, 1);
        check("heat_no_to", sig_to, 0);
      end
    end

    // Conflicting operations.
    set_ops(0, 0, 1, 0, 1);
    repeat (5) step();
    check("conflict_flag", op_conflict, 1);
    check("conflict_phase", phase, int'(PhIdle));

    // Fault mid-spin.
    set_ops(0, 0, 0, 0, 1);
    step();
    for (int k = 0; k < 150; k++) step();
    check("spin_count_150", phase_count, 150);
    fault = 1'b1;
    step();
    check("fault_phase", phase, int'(PhIdle));
    check("fault_count", phase_count, 0);
    fault = 1'b0;
    set_ops(0, 0, 0, 0, 0);
    step();

    // Reset mid-wash.
    set_ops(0, 0, 1, 0, 0);
    step();
    for (int k = 0; k < 100; k++) step();
    reset = 1'b1;
    step();
    check("reset_mid_count", phase_count, 0);
    check("reset_mid_phase", phase, int'(PhIdle));
    reset = 1'b0;
    set_ops(0, 0, 0, 0, 0);

    // Randomized segments of operations and sensor values around the thresholds.
    for (int seg = 0; seg < 60; seg++) begin
      int kind, len, b;
      kind = int'($urandom_range(0, 11));
      len  = int'($urandom_range(1, 60));
      set_ops(0, 0, 0, 0, 0);
      if (kind == 1) begin
        b = int'($urandom_range(0, 4));
        set_ops(b == 0, b == 1, b == 2, b == 3, b == 4);
        b = (b + int'($urandom_range(1, 4))) % 5;
        if (b == 0) fill_op = 1; else if (b == 1) heat_op = 1; else if (b == 2) wash_op = 1;
        else if (b == 3) rinse_op = 1; else spin_op = 1;
      end else if (kind >= 2 && kind <= 9) begin
        b = int'($urandom_range(0, 4));
        set_ops(b == 0, b == 1, b == 2, b == 3, b == 4);
        if ($urandom_range(0, 3) == 0) len = int'($urandom_range(150, 650));
      end
      for (int c = 0; c < len; c++) begin
        fault = (kind == 10) && ($urandom_range(0, 7) == 0);
        reset = (kind == 11) && ($urandom_range(0, 7) == 0);
        level = 8'($urandom_range(185, 220));
        temp  = 8'($urandom_range(50, 70));
        step();
      end
      fault = 1'b0;
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
